// File: rtl/result_readout_controller.sv
`default_nettype none
// ============================================================================
// Module      : result_readout_controller
// Description : Reader side of the byte-serial operand loader. Captures an
//               adder result plus carry-out and shows it one byte at a time
//               on the board LEDs. Byte stepping uses the set/unlock button
//               lock protocol; an optional timer auto-advances the byte.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               result, cout_in - adder sum / carry-out to capture
//               load, next      - level buttons: capture / advance byte
//               unlock          - level button: clear lock
//               auto            - switch: timer-driven byte advance
//               out, index      - selected byte of held result and its number
//               coutled         - held carry-out
//               validled        - a result has been captured
//               lockled         - current lock state
// Revision    : 1.0 - initial release
// ============================================================================
module result_readout_controller #(
    parameter int DATA_W        = 32,
    parameter int BYTE_W        = 8,
    parameter int SCROLL_CYCLES = 50000000,
    localparam int NUM_BYTES    = DATA_W / BYTE_W,
    localparam int IDX_W        = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] result,
    input  logic              cout_in,
    input  logic              load,
    input  logic              next,
    input  logic              unlock,
    input  logic              auto,
    output logic [BYTE_W-1:0] out,
    output logic [IDX_W-1:0]  index,
    output logic              coutled,
    output logic              validled,
    output logic              lockled
);

    localparam int              TIMER_W      = $clog2(SCROLL_CYCLES);
    localparam logic [TIMER_W-1:0] c_TIMER_LAST = TIMER_W'(SCROLL_CYCLES - 1);
    localparam logic [IDX_W-1:0]   c_IDX_LAST   = IDX_W'(NUM_BYTES - 1);

    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_SHOW  = 1'b1
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [DATA_W-1:0]  r_hold,  w_hold_nxt;
    logic               r_cout,  w_cout_nxt;
    logic [IDX_W-1:0]   r_index, w_index_nxt;
    logic               r_lock,  w_lock_nxt;
    logic [TIMER_W-1:0] r_timer, w_timer_nxt;

    logic               w_valid;
    logic               w_load_acc;
    logic               w_next_acc;
    logic [IDX_W-1:0]   w_index_inc;
    logic [31:0]        w_sel_base;

    assign w_valid     = (r_state == S_SHOW);
    assign w_load_acc  = load && !r_lock;
    // load has priority, so a simultaneous next is dropped
    assign w_next_acc  = next && !r_lock && w_valid && !load;
    assign w_index_inc = (r_index == c_IDX_LAST) ? '0 : r_index + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_EMPTY;
            r_hold  <= '0;
            r_cout  <= 1'b0;
            r_index <= '0;
            r_lock  <= 1'b0;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_hold  <= w_hold_nxt;
            r_cout  <= w_cout_nxt;
            r_index <= w_index_nxt;
            r_lock  <= w_lock_nxt;
            r_timer <= w_timer_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        w_cout_nxt  = r_cout;
        w_index_nxt = r_index;
        w_lock_nxt  = r_lock;
        w_timer_nxt = '0;

        if (w_load_acc) begin
            w_state_nxt = S_SHOW;
            w_hold_nxt  = result;
            w_cout_nxt  = cout_in;
            w_index_nxt = '0;
            w_lock_nxt  = 1'b1;
        end else if (w_next_acc) begin
            w_index_nxt = w_index_inc;
            w_lock_nxt  = 1'b1;
        end else begin
            // Reaching here with lock=1 means nothing was accepted this cycle
            if (unlock && r_lock) begin
                w_lock_nxt = 1'b0;
            end
            // Auto-scroll runs independently of the button lock
            if (auto && w_valid) begin
                if (r_timer == c_TIMER_LAST) begin
                    w_index_nxt = w_index_inc;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
        end
    end

    assign w_sel_base = 32'(r_index) * 32'(BYTE_W);
    assign out        = r_hold[w_sel_base +: BYTE_W];
    assign index      = r_index;
    assign coutled    = r_cout;
    assign validled   = w_valid;
    assign lockled    = r_lock;

endmodule
`default_nettype wire

// File: tb/tb_result_readout_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_result_readout_controller
// Description : Self-checking bench for result_readout_controller using a
//               table of single-cycle vectors plus hand-written multi-cycle
//               sequences (held button, auto-scroll, reset mid-scroll).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_result_readout_controller;

    logic        clk;
    logic        rst;
    logic [31:0] result;
    logic        cout_in;
    logic        load;
    logic        next;
    logic        unlock;
    logic        auto;
    logic [7:0]  out;
    logic [1:0]  index;
    logic        coutled;
    logic        validled;
    logic        lockled;

    int n_cmp = 0;
    int n_bad = 0;

    result_readout_controller #(
        .DATA_W        (32),
        .BYTE_W        (8),
        .SCROLL_CYCLES (4)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .result   (result),
        .cout_in  (cout_in),
        .load     (load),
        .next     (next),
        .unlock   (unlock),
        .auto     (auto),
        .out      (out),
        .index    (index),
        .coutled  (coutled),
        .validled (validled),
        .lockled  (lockled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic        ld;
        logic        nx;
        logic        ul;
        logic        au;
        logic [31:0] res;
        logic        cin;
        logic [7:0]  eout;
        logic [1:0]  eidx;
        logic        ecout;
        logic        evalid;
        logic        elock;
    } vec_t;

    vec_t tbl[$];

    task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive at the falling edge, let one rising edge pass, sample 1 time unit later
    task automatic step(input logic r, input logic l, input logic n, input logic u,
                        input logic a, input logic [31:0] res, input logic c);
        @(negedge clk);
        rst = r; load = l; next = n; unlock = u; auto = a; result = res; cout_in = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [7:0] eo, input logic [1:0] ei,
                         input logic ec, input logic ev, input logic el);
        cmp({nm, ".out"},      out,             eo);
        cmp({nm, ".index"},    {6'd0, index},   {6'd0, ei});
        cmp({nm, ".coutled"},  {7'd0, coutled}, {7'd0, ec});
        cmp({nm, ".validled"}, {7'd0, validled},{7'd0, ev});
        cmp({nm, ".lockled"},  {7'd0, lockled}, {7'd0, el});
    endtask

    function automatic logic [7:0] byte_of(input logic [31:0] w, input int i);
        logic [31:0] s;
        s = w >> (8 * i);
        return s[7:0];
    endfunction

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [31:0] auto_val;
        int          k;

        rst = 1'b1; load = 1'b0; next = 1'b0; unlock = 1'b0; auto = 1'b0;
        result = '0; cout_in = 1'b0;

        //            rst  ld   nx   ul   au   result        cin  | out    idx   cout valid lock
        tbl.push_back({1'b1,1'b0,1'b0,1'b0,1'b0,32'h0000_0000,1'b0, 8'h00, 2'd0, 1'b0,1'b0,1'b0}); // reset
        tbl.push_back({1'b1,1'b1,1'b1,1'b1,1'b1,32'h1234_5678,1'b1, 8'h00, 2'd0, 1'b0,1'b0,1'b0}); // reset wins
        tbl.push_back({1'b0,1'b0,1'b1,1'b0,1'b0,32'h0000_0000,1'b0, 8'h00, 2'd0, 1'b0,1'b0,1'b0}); // next in EMPTY
        tbl.push_back({1'b0,1'b1,1'b0,1'b0,1'b0,32'h1234_5678,1'b1, 8'h78, 2'd0, 1'b1,1'b1,1'b1}); // capture
        tbl.push_back({1'b0,1'b0,1'b0,1'b0,1'b0,32'hFFFF_FFFF,1'b0, 8'h78, 2'd0, 1'b1,1'b1,1'b1}); // input change ignored
        tbl.push_back({1'b0,1'b0,1'b1,1'b0,1'b0,32'hFFFF_FFFF,1'b0, 8'h78, 2'd0, 1'b1,1'b1,1'b1}); // next while locked
        tbl.push_back({1'b0,1'b0,1'b1,1'b1,1'b0,32'hFFFF_FFFF,1'b0, 8'h78, 2'd0, 1'b1,1'b1,1'b0}); // unlock only
        tbl.push_back({1'b0,1'b0,1'b1,1'b0,1'b0,32'hFFFF_FFFF,1'b0, 8'h56, 2'd1, 1'b1,1'b1,1'b1}); // step 1
        tbl.push_back({1'b0,1'b0,1'b1,1'b1,1'b0,32'hFFFF_FFFF,1'b0, 8'h56, 2'd1, 1'b1,1'b1,1'b0});
        tbl.push_back({1'b0,1'b0,1'b1,1'b0,1'b0,32'hFFFF_FFFF,1'b0, 8'h34, 2'd2, 1'b1,1'b1,1'b1}); // step 2
        tbl.push_back({1'b0,1'b0,1'b1,1'b1,1'b0,32'hFFFF_FFFF,1'b0, 8'h34, 2'd2, 1'b1,1'b1,1'b0});
        tbl.push_back({1'b0,1'b0,1'b1,1'b0,1'b0,32'hFFFF_FFFF,1'b0, 8'h12, 2'd3, 1'b1,1'b1,1'b1}); // step 3
        tbl.push_back({1'b0,1'b0,1'b1,1'b1,1'b0,32'hFFFF_FFFF,1'b0, 8'h12, 2'd3, 1'b1,1'b1,1'b0});
        tbl.push_back({1'b0,1'b0,1'b1,1'b0,1'b0,32'hFFFF_FFFF,1'b0, 8'h78, 2'd0, 1'b1,1'b1,1'b1}); // wrap
        tbl.push_back({1'b0,1'b1,1'b0,1'b0,1'b0,32'hFFFF_FFFF,1'b0, 8'h78, 2'd0, 1'b1,1'b1,1'b1}); // load while locked
        tbl.push_back({1'b0,1'b0,1'b0,1'b1,1'b0,32'hFFFF_FFFF,1'b0, 8'h78, 2'd0, 1'b1,1'b1,1'b0});
        tbl.push_back({1'b0,1'b1,1'b1,1'b0,1'b0,32'hCAFE_BABE,1'b0, 8'hBE, 2'd0, 1'b0,1'b1,1'b1}); // load+next
        tbl.push_back({1'b0,1'b0,1'b0,1'b1,1'b0,32'h0000_0000,1'b0, 8'hBE, 2'd0, 1'b0,1'b1,1'b0});
        tbl.push_back({1'b0,1'b0,1'b1,1'b0,1'b0,32'h0000_0000,1'b0, 8'hBA, 2'd1, 1'b0,1'b1,1'b1});
        tbl.push_back({1'b0,1'b0,1'b0,1'b1,1'b0,32'h0000_0000,1'b0, 8'hBA, 2'd1, 1'b0,1'b1,1'b0});
        tbl.push_back({1'b0,1'b1,1'b1,1'b0,1'b0,32'h1122_3344,1'b1, 8'h44, 2'd0, 1'b1,1'b1,1'b1}); // reload from idx 1
        tbl.push_back({1'b1,1'b0,1'b0,1'b0,1'b0,32'h0000_0000,1'b0, 8'h00, 2'd0, 1'b0,1'b0,1'b0}); // reset while locked

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].ld, tbl[i].nx, tbl[i].ul, tbl[i].au, tbl[i].res, tbl[i].cin);
            check($sformatf("vec%0d", i), tbl[i].eout, tbl[i].eidx, tbl[i].ecout,
                  tbl[i].evalid, tbl[i].elock);
        end

        // next held for 10 cycles after one unlock advances exactly once
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0102_0304, 1'b0);
        check("hold_load", 8'h04, 2'd0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        check("hold_unlock", 8'h04, 2'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
            check($sformatf("hold_next%0d", i), 8'h03, 2'd1, 1'b0, 1'b1, 1'b1);
        end

        // Auto-scroll with a 4-cycle period
        auto_val = 32'hA1B2_C3D4;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check("auto_rst", 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
        check("auto_empty", 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, auto_val, 1'b0);
        check("auto_load", 8'hD4, 2'd0, 1'b0, 1'b1, 1'b1);
        for (k = 1; k <= 17; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
            check($sformatf("auto%0d", k), byte_of(auto_val, (k / 4) % 4),
                  2'((k / 4) % 4), 1'b0, 1'b1, 1'b1);
        end
        // auto=0 freezes the index (currently 0, timer part-way)
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
            check($sformatf("freeze%0d", i), 8'hD4, 2'd0, 1'b0, 1'b1, 1'b1);
        end
        // Re-enable: timer restarted from 0, so index 2 is reached after 8 cycles
        for (k = 1; k <= 9; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
            check($sformatf("resume%0d", k), byte_of(auto_val, k / 4),
                  2'(k / 4), 1'b0, 1'b1, 1'b1);
        end
        // Reset mid-scroll at index 2
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
        check("midrst", 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, auto_val, 1'b1);
        check("reload", 8'hD4, 2'd0, 1'b1, 1'b1, 1'b1);
        for (k = 1; k <= 4; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
            check($sformatf("restart%0d", k), byte_of(auto_val, k / 4),
                  2'(k / 4), 1'b1, 1'b1, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
